// File: rtl/seg7_reg_monitor.sv
// seg7_reg_monitor: 4-digit multiplexed 7-segment display of CPU debug registers with debounced page select
module seg7_reg_monitor #(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] output1,
   input  logic [31:0] output2,
   input  logic        page_btn,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic [1:0]  page
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   logic          sync1_q, sync2_q, db_q, db_d, db_dly_q;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]    page_q, page_d, dig_q, dig_d;
   logic [SW-1:0] scan_q, scan_d;
   logic          scan_wrap;
   logic [15:0]   snap_q, snap_d, sel;
   logic [3:0]    nib, an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   // Button debounce: accept a new level only after it has been stable long enough; step page on accepted press
   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
         db_cnt_d = db_cnt_q + 1'b1;
         if (db_cnt_q == DB_MAX) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
         end
      end
      page_d = (db_q && !db_dly_q) ? page_q + 2'd1 : page_q;
   end
   // Digit scan, frame-boundary snapshot and registered display drive
   always_comb begin
      scan_wrap = scan_q == SCAN_MAX;
      scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
      dig_d     = scan_wrap ? dig_q + 2'd1 : dig_q;
      sel       = page_q[1] ? (page_q[0] ? output2[31:16] : output2[15:0])
                            : (page_q[0] ? output1[31:16] : output1[15:0]);
      snap_d    = (scan_wrap && dig_q == 2'd3) ? sel : snap_q;
      nib       = snap_q[{dig_q, 2'b00} +: 4];
      an_d      = ~(4'b0001 << dig_q);
      seg_d     = {dig_q != page_q, GLYPH[nib]};
   end
   // State registers; reset blanks the display immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         db_cnt_q <= '0;
         page_q   <= 2'd0;
         scan_q   <= '0;
         dig_q    <= 2'd0;
         snap_q   <= 16'h0000;
         an_q     <= 4'b1111;
         seg_q    <= 8'hFF;
      end else begin
         sync1_q  <= page_btn;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         db_cnt_q <= db_cnt_d;
         page_q   <= page_d;
         scan_q   <= scan_d;
         dig_q    <= dig_d;
         snap_q   <= snap_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end
   assign an   = an_q;
   assign seg  = seg_q;
   assign page = page_q;
endmodule

// File: tb/tb_seg7_reg_monitor.sv
// tb_seg7_reg_monitor: directed self-checking bench for seg7_reg_monitor
module tb_seg7_reg_monitor;
   logic        clk, reset, page_btn;
   logic [31:0] output1, output2;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [1:0]  page;
   int checks = 0, failures = 0, edge_n = 0;
   logic [1:0] exp_page = 2'd0;
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seg7_reg_monitor #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .output1(output1), .output2(output2),
      .page_btn(page_btn), .an(an), .seg(seg), .page(page)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      edge_n++;
   endtask

   task automatic goto(int k);
      while (edge_n < k) tick();
   endtask

   task automatic check_frame(int start, logic [15:0] val, logic [1:0] pg, bit chg);
      int d;
      logic [3:0] nb, ea;
      logic [7:0] es;
      for (int k = start; k < start + 16; k++) begin
         goto(k);
         d  = (k - start) / 4;
         nb = val[4*d +: 4];
         ea = ~(4'b0001 << d);
         es = {d != int'(pg), GLYPH[nb]};
         chk("an", {28'd0, an}, {28'd0, ea});
         chk("seg", {24'd0, seg}, {24'd0, es});
         if (chg && k == start + 5) output1 = 32'h0000FFFF;
      end
   endtask

   task automatic press();
      int p;
      p = edge_n;
      page_btn = 1'b1;
      goto(p + 10);
      chk("page_hold", {30'd0, page}, {30'd0, exp_page});
      goto(p + 11);
      exp_page = exp_page + 2'd1;
      chk("page_step", {30'd0, page}, {30'd0, exp_page});
      goto(p + 20);
      page_btn = 1'b0;
      goto(p + 40);
   endtask

   initial begin
      reset = 1'b1; page_btn = 1'b0; output1 = 32'h12345678; output2 = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_page", {30'd0, page}, 32'h0);
      reset = 1'b0;
      edge_n = 0;
      check_frame(1, 16'h0000, 2'd0, 1'b0);
      check_frame(17, 16'h5678, 2'd0, 1'b0);
      press();
      check_frame(81, 16'h1234, 2'd1, 1'b0);
      output2 = 32'hDEADBEEF;
      for (int i = 0; i < 10; i++) begin
         goto(96 + 3*i);
         page_btn = (i % 2 == 0);
      end
      goto(126);
      chk("bounce_none", {30'd0, page}, 32'd1);
      page_btn = 1'b1;
      goto(136);
      chk("bounce_hold", {30'd0, page}, 32'd1);
      goto(137);
      chk("bounce_once", {30'd0, page}, 32'd2);
      exp_page = 2'd2;
      for (int i = 0; i < 10; i++) begin
         goto(146 + 3*i);
         page_btn = (i % 2 == 1);
      end
      goto(176);
      page_btn = 1'b0;
      goto(190);
      chk("release_none", {30'd0, page}, 32'd2);
      goto(192);
      press();
      press();
      press();
      press();
      check_frame(353, 16'hBEEF, 2'd2, 1'b0);
      press();
      check_frame(417, 16'hDEAD, 2'd3, 1'b0);
      press();
      chk("wrap_page", {30'd0, page}, 32'd0);
      check_frame(481, 16'h5678, 2'd0, 1'b1);
      check_frame(497, 16'hFFFF, 2'd0, 1'b0);
      goto(517);
      page_btn = 1'b1;
      goto(527);
      chk("bnd_pre", {30'd0, page}, 32'd0);
      goto(528);
      chk("bnd_step", {30'd0, page}, 32'd1);
      check_frame(529, 16'hFFFF, 2'd1, 1'b0);
      page_btn = 1'b0;
      check_frame(561, 16'h0000, 2'd1, 1'b0);
      goto(578);
      #2 reset = 1'b1;
      #1;
      chk("arst_an", {28'd0, an}, 32'hF);
      chk("arst_seg", {24'd0, seg}, 32'hFF);
      chk("arst_page", {30'd0, page}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      edge_n = 0;
      check_frame(1, 16'h0000, 2'd0, 1'b0);
      check_frame(17, 16'hFFFF, 2'd0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
